// File: rtl/img_downsample_28_if.sv
// img_downsample_28_if
// Groups the pixel-stream signals of the decimator. The slave modport is the
// decimator's view: the camera stream arrives on iFVAL/iLVAL/iDVAL/iDATA and
// the decimated 28x28 frame leaves on oFVAL/oDVAL/oDATA/oFrame_done. The
// master modport is the view of whatever drives the stream and consumes the
// output.
interface img_downsample_28_if;
    logic        iFVAL;        // input frame valid
    logic        iLVAL;        // input line valid
    logic        iDVAL;        // input pixel valid (qualified by iLVAL)
    logic [11:0] iDATA;        // grayscale input pixel
    logic        oFVAL;        // output frame valid
    logic        oDVAL;        // output pixel valid, single-cycle pulses
    logic [15:0] oDATA;        // {4'h0, avg}
    logic        oFrame_done;  // pulse after the last output pixel

    modport slave (
        input  iFVAL, iLVAL, iDVAL, iDATA,
        output oFVAL, oDVAL, oDATA, oFrame_done
    );

    modport master (
        output iFVAL, iLVAL, iDVAL, iDATA,
        input  oFVAL, oDVAL, oDATA, oFrame_done
    );
endinterface

// File: rtl/img_downsample_28.sv
// img_downsample_28
// Crops a centred window out of the full-resolution grayscale stream,
// box-averages each (2^TS_LOG2)^2 tile and emits the NT x NT result as a
// raster stream (row-major, column-minor) for the capture FSM.
//
// Ports:
//   pxlclk  pixel clock, rising edge
//   rst     asynchronous active-high reset
//   bus     img_downsample_28_if.slave (iFVAL/iLVAL/iDVAL/iDATA in,
//           oFVAL/oDVAL/oDATA/oFrame_done out)
//
// Build option: define IMG_INVERT_EN to emit 12'hFFF - avg instead of avg.
//
// TS_LOG2/NT default to 16x16 tiles and a 28x28 output (448x448 window);
// they exist so that scaled-down instances share the same datapath.
module img_downsample_28 #(
    parameter int IN_W    = 640,
    parameter int IN_H    = 480,
    parameter int X_OFF   = 96,
    parameter int Y_OFF   = 16,
    parameter int TS_LOG2 = 4,
    parameter int NT      = 28
) (
    input  logic pxlclk,
    input  logic rst,
    img_downsample_28_if.slave bus
);
    localparam int         WIN   = NT << TS_LOG2;
    localparam int         CW    = $clog2(NT);
    localparam logic [9:0] TOTAL = 10'(NT * NT);
    localparam logic [9:0] XW    = 10'(IN_W);
    localparam logic [9:0] XLO   = 10'(X_OFF);
    localparam logic [9:0] XHI   = 10'(X_OFF + WIN);
    localparam logic [8:0] YH    = 9'(IN_H);
    localparam logic [8:0] YLO   = 9'(Y_OFF);
    localparam logic [8:0] YHI   = 9'(Y_OFF + WIN);
    localparam logic [9:0] XMSK  = 10'((1 << TS_LOG2) - 1);
    localparam logic [8:0] YMSK  = 9'((1 << TS_LOG2) - 1);

    typedef enum logic [1:0] {WAIT_FRAME, ACTIVE, DONE} state_t;

    state_t      state_q, state_d;
    logic        fval_q, lval_q;
    logic [9:0]  x_q, x_d, x_cur;
    logic [8:0]  y_q, y_d, y_cur;
    logic [9:0]  cnt_q, cnt_d;
    logic        dval_q, done_q, done_d;
    logic [15:0] data_q, pix;
    logic [19:0] acc_q [NT];

    logic        frame_start, lval_rise, lval_fall, accept;
    logic        in_win, tile_end, run, clr_acc, emit;
    logic [9:0]  xo;
    logic [8:0]  yo;
    logic [CW-1:0] col;
    logic [19:0] sum;
    logic [11:0] avg;

    assign frame_start = bus.iFVAL & ~fval_q;
    assign lval_rise   = bus.iLVAL & ~lval_q;
    assign lval_fall   = ~bus.iLVAL & lval_q;
    assign accept      = bus.iLVAL & bus.iDVAL;

    // The pixel arriving with the line (or frame) start is column/line 0.
    assign x_cur = (lval_rise | frame_start) ? '0 : x_q;
    assign y_cur = frame_start ? '0 : y_q;
    // Saturate so an over-long line can never wrap back into the window.
    assign x_d   = (accept && x_cur != '1) ? x_cur + 10'd1 : x_cur;
    assign y_d   = frame_start ? '0 : ((lval_fall && y_q != '1) ? y_q + 9'd1 : y_q);

    assign in_win = accept && (x_cur < XW) && (y_cur < YH) &&
                    (x_cur >= XLO) && (x_cur < XHI) &&
                    (y_cur >= YLO) && (y_cur < YHI);

    assign xo       = x_cur - XLO;
    assign yo       = y_cur - YLO;
    assign col      = CW'(xo >> TS_LOG2);
    assign tile_end = ((xo & XMSK) == XMSK) && ((yo & YMSK) == YMSK);

    // The closing pixel is folded in directly so the tile can be emitted
    // and its accumulator reused in the same cycle.
    assign sum = acc_q[col] + 20'(bus.iDATA);
    assign avg = 12'(sum >> (2 * TS_LOG2));

`ifdef IMG_INVERT_EN
    assign pix = {4'h0, 12'hFFF - avg};
`else
    assign pix = {4'h0, avg};
`endif

    assign emit = run & in_win & tile_end;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_acc = 1'b0;
        run     = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            WAIT_FRAME: begin
                if (frame_start) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                    clr_acc = 1'b1;
                end
            end
            ACTIVE: begin
                // Last pixel went out on the previous edge: drop oFVAL and
                // pulse done together, one cycle after the final oDVAL.
                if (cnt_q == TOTAL) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (!bus.iFVAL) begin
                    state_d = WAIT_FRAME;
                    clr_acc = 1'b1;
                end else begin
                    run = 1'b1;
                    if (emit) cnt_d = cnt_q + 10'd1;
                end
            end
            DONE: begin
                if (!bus.iFVAL) state_d = WAIT_FRAME;
            end
            default: state_d = WAIT_FRAME;
        endcase
    end

    always_ff @(posedge pxlclk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_FRAME;
            fval_q  <= 1'b1;   // a frame in flight at release is skipped
            lval_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            dval_q  <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fval_q  <= bus.iFVAL;
            lval_q  <= bus.iLVAL;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            dval_q  <= emit;
            done_q  <= done_d;
            if (emit) data_q <= pix;
        end
    end

    always_ff @(posedge pxlclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NT; i++) acc_q[i] <= '0;
        end else if (clr_acc) begin
            for (int i = 0; i < NT; i++) acc_q[i] <= '0;
        end else if (run && in_win) begin
            acc_q[col] <= tile_end ? '0 : sum;
        end
    end

    assign bus.oFVAL       = (state_q == ACTIVE);
    assign bus.oDVAL       = dval_q;
    assign bus.oDATA       = data_q;
    assign bus.oFrame_done = done_q;
endmodule

// File: tb/tb_img_downsample_28.sv
// tb_img_downsample_28
// Two scaled-down decimators share one 64x60 input stream (crop offset 4,2):
//   A: 2x2 tiles, 28x28 output (784 pixels per frame, window 56x56)
//   B: 16x16 tiles, 2x2 output (full-size tile, exercises the 20-bit sum)
// Frames come from a record table; reset sequences are written out by hand.
module tb_img_downsample_28;
    localparam int IN_W = 64;
    localparam int IN_H = 60;
    localparam int XO   = 4;
    localparam int YO   = 2;

    typedef struct {
        int mode;    // pixel pattern
        int nlines;  // lines sent before iFVAL drops (IN_H = full frame)
        int expA;    // output pulses from A
        int expB;    // output pulses from B
        int a0;      // first A pixel (un-inverted average)
        int b0;      // first B pixel (un-inverted average)
    } vec_t;

    vec_t tbl[7];

    logic pxlclk, rst;
    logic iFVAL, iLVAL, iDVAL;
    logic [11:0] iDATA;

    img_downsample_28_if busA();
    img_downsample_28_if busB();

    assign busA.iFVAL = iFVAL;  assign busB.iFVAL = iFVAL;
    assign busA.iLVAL = iLVAL;  assign busB.iLVAL = iLVAL;
    assign busA.iDVAL = iDVAL;  assign busB.iDVAL = iDVAL;
    assign busA.iDATA = iDATA;  assign busB.iDATA = iDATA;

    img_downsample_28 #(.IN_W(IN_W), .IN_H(IN_H), .X_OFF(XO), .Y_OFF(YO),
                        .TS_LOG2(1), .NT(28))
        dutA (.pxlclk(pxlclk), .rst(rst), .bus(busA));
    img_downsample_28 #(.IN_W(IN_W), .IN_H(IN_H), .X_OFF(XO), .Y_OFF(YO),
                        .TS_LOG2(4), .NT(2))
        dutB (.pxlclk(pxlclk), .rst(rst), .bus(busB));

    initial pxlclk = 1'b0;
    always #5 pxlclk = ~pxlclk;

    int nchk = 0, npass = 0;
    int naA, naB, doneA, doneB, perrA, perrB, fvhA, fvhB;
    int outA[784];
    int outB[4];
    logic prvA, prvB;
    logic [15:0] lastA, lastB;

    function automatic int fix(input int avg);
`ifdef IMG_INVERT_EN
        return 4095 - avg;
`else
        return avg;
`endif
    endfunction

    function automatic int pix(input int mode, input int x, input int y);
        case (mode)
            0: return 'h800;
            1: return x & 'hFFF;
            2: return (x >= 4 && x < 60 && y >= 2 && y < 58) ? 0 : 'hFFF;
            3: return 'hFFF;
            default: return (x * 7 + y * 13) & 'hFFF;
        endcase
    endfunction

    // Direct tile sum over the stimulus pattern.
    function automatic int model(input int mode, input int ts, input int nt, input int k);
        int t, r, c, s;
        t = 1 << ts; r = k / nt; c = k % nt; s = 0;
        for (int i = 0; i < t; i++)
            for (int j = 0; j < t; j++)
                s += pix(mode, XO + c * t + i, YO + r * t + j);
        return fix(s >> (2 * ts));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic tick();
        @(posedge pxlclk);
        #1;
    endtask

    task automatic clear_mon();
        naA = 0; naB = 0; doneA = 0; doneB = 0;
        perrA = 0; perrB = 0; fvhA = 0; fvhB = 0;
    endtask

    // One missing iDVAL per line checks that x counts accepted pixels only.
    task automatic drive_lines(input int mode, input int n);
        for (int y = 0; y < n; y++) begin
            int xa;
            xa = 0;
            iLVAL = 1'b1;
            for (int k = 0; k < IN_W + 1; k++) begin
                if (k == 10) iDVAL = 1'b0;
                else begin
                    iDVAL = 1'b1;
                    iDATA = 12'(pix(mode, xa, y));
                    xa++;
                end
                tick();
            end
            iLVAL = 1'b0; iDVAL = 1'b0;
            repeat (4) tick();
        end
    endtask

    task automatic run_frame(input int i);
        vec_t v;
        int bad, full;
        v = tbl[i];
        full = (v.nlines == IN_H) ? 1 : 0;
        clear_mon();
        iFVAL = 1'b1;
        repeat (3) tick();
        chk("fval_rise", int'({busA.oFVAL, busB.oFVAL}), 3);
        drive_lines(v.mode, v.nlines);
        if (full == 1) chk("fval_end", int'({busA.oFVAL, busB.oFVAL}), 0);
        else           chk("fval_pre_abort", int'({busA.oFVAL, busB.oFVAL}), 3);
        iFVAL = 1'b0;
        tick();
        chk("fval_fall", int'({busA.oFVAL, busB.oFVAL}), 0);
        repeat (6) tick();
        chk("cntA", naA, v.expA);
        chk("cntB", naB, v.expB);
        chk("doneA", doneA, full);
        chk("doneB", doneB, full);
        bad = 0;
        for (int k = 0; k < naA && k < 784; k++)
            if (outA[k] != model(v.mode, 1, 28, k)) begin
                if (bad == 0) $display("note: frame %0d A pixel %0d got %h want %h", i, k, outA[k], model(v.mode, 1, 28, k));
                bad++;
            end
        chk("dataA", bad, 0);
        bad = 0;
        for (int k = 0; k < naB && k < 4; k++)
            if (outB[k] != model(v.mode, 4, 2, k)) begin
                if (bad == 0) $display("note: frame %0d B pixel %0d got %h want %h", i, k, outB[k], model(v.mode, 4, 2, k));
                bad++;
            end
        chk("dataB", bad, 0);
        if (naA > 0) chk("firstA", outA[0], fix(v.a0));
        if (naB > 0) chk("firstB", outB[0], fix(v.b0));
        chk("protoA", perrA, 0);
        chk("protoB", perrB, 0);
    endtask

    // Output monitor: collects pixels, checks oDATA hold, oDVAL inside oFVAL,
    // and that done lands one cycle after the final pulse with oFVAL low.
    always @(negedge pxlclk) begin
        if (rst) begin
            prvA = 1'b0; prvB = 1'b0; lastA = '0; lastB = '0;
        end else begin
            if (busA.oDVAL) begin
                if (naA < 784) outA[naA] = int'(busA.oDATA);
                naA++;
                if (!busA.oFVAL) perrA++;
            end else if (busA.oDATA != lastA) perrA++;
            if (busA.oFrame_done) begin
                doneA++;
                if (!prvA || busA.oFVAL || naA != 784) perrA++;
            end
            if (busA.oFVAL) fvhA++;
            prvA = busA.oDVAL; lastA = busA.oDATA;

            if (busB.oDVAL) begin
                if (naB < 4) outB[naB] = int'(busB.oDATA);
                naB++;
                if (!busB.oFVAL) perrB++;
            end else if (busB.oDATA != lastB) perrB++;
            if (busB.oFrame_done) begin
                doneB++;
                if (!prvB || busB.oFVAL || naB != 4) perrB++;
            end
            if (busB.oFVAL) fvhB++;
            prvB = busB.oDVAL; lastB = busB.oDATA;
        end
    end

    initial begin
        //         mode lines  A    B   a0     b0
        tbl[0] = '{0,   60,   784, 4, 'h800, 'h800};  // constant
        tbl[1] = '{1,   60,   784, 4, 4,     11};     // gradient x
        tbl[2] = '{2,   60,   784, 4, 0,     0};      // crop edges
        tbl[3] = '{4,   20,   252, 2, 64,    204};    // abort after line 20
        tbl[4] = '{4,   60,   784, 4, 64,    204};    // recovery frame
        tbl[5] = '{3,   60,   784, 4, 'hFFF, 'hFFF};  // max tile sum
        tbl[6] = '{0,   60,   784, 4, 'h800, 'h800};  // back-to-back, no residue

        rst = 1'b1; iFVAL = 1'b0; iLVAL = 1'b0; iDVAL = 1'b0; iDATA = '0;
        clear_mon();
        repeat (3) tick();
        chk("rst_fval", int'({busA.oFVAL, busB.oFVAL}), 0);
        chk("rst_dval", int'({busA.oDVAL, busB.oDVAL}), 0);
        chk("rst_dataA", int'(busA.oDATA), 0);
        chk("rst_done", int'({busA.oFrame_done, busB.oFrame_done}), 0);
        rst = 1'b0;
        repeat (3) tick();

        for (int i = 0; i < 7; i++) run_frame(i);

        // Reset asserted mid-frame: outputs clear without waiting for an edge.
        clear_mon();
        iFVAL = 1'b1;
        repeat (3) tick();
        drive_lines(0, 10);
        chk("pre_rst_fvalA", int'(busA.oFVAL), 1);
        chk("pre_rst_dataA", int'(busA.oDATA), fix('h800));
        rst = 1'b1;
        #1;
        chk("async_rst_fval", int'({busA.oFVAL, busB.oFVAL}), 0);
        chk("async_rst_dataA", int'(busA.oDATA), 0);
        repeat (3) tick();

        // Reset released while iFVAL is still high: this frame is skipped.
        rst = 1'b0;
        clear_mon();
        tick();
        drive_lines(0, IN_H);
        iFVAL = 1'b0;
        repeat (6) tick();
        chk("skip_cnt", naA + naB, 0);
        chk("skip_done", doneA + doneB, 0);
        chk("skip_fval", fvhA + fvhB, 0);

        run_frame(1);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
